// File: rtl/pwm_led_ctrl_if.sv
// Store/load bus between the core's data-memory path and the PWM LED peripheral.
// The core side uses the master modport and the peripheral uses the slave modport.
interface pwm_led_ctrl_if;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        hit;
    logic [31:0] read_data;

    modport master (
        output write_mem,
        output funct3,
        output address,
        output write_data,
        input  hit,
        input  read_data
    );

    modport slave (
        input  write_mem,
        input  funct3,
        input  address,
        input  write_data,
        output hit,
        output read_data
    );
endinterface

// File: rtl/pwm_led_ctrl.sv
// Memory-mapped 4-channel PWM LED controller (R, G, B, LED) with period-aligned duty updates.
// Optional macro PWM_LED_FADE_EN: duty steps by +/-1 per period toward the shadow value.
module pwm_led_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter logic [15:0] PRESCALE_RST = 16'd46
) (
    input  logic           clk,
    input  logic           reset,
    pwm_led_ctrl_if.slave  bus,
    output logic           led,
    output logic           red,
    output logic           green,
    output logic           blue
);

    logic        en_reg;
    logic [15:0] prescale_reg;
    logic [15:0] pre_cnt_reg;
    logic [7:0]  pwm_cnt_reg;
    logic [31:0] read_data_reg;

    logic [1:0]  sel;
    logic [3:0]  byte_en;
    logic [31:0] wr_lanes;
    logic        wr_en;
    logic        tick;
    logic        boundary;
    logic [31:0] shadow_bus;
    logic [23:0] active_bus;
    logic [3:0]  pwm_out;
    logic [31:0] read_word;

    assign bus.hit   = (bus.address[31:4] == BASE_ADDR[31:4]);
    assign sel       = bus.address[3:2];
    assign wr_en     = bus.write_mem && bus.hit;

    // Store data arrives unshifted (rs2v), so replicate it across the lanes it may target.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = bus.write_data;
        case (bus.funct3)
            3'd0: begin
                byte_en  = 4'b0001 << bus.address[1:0];
                wr_lanes = {4{bus.write_data[7:0]}};
            end
            3'd1: begin
                if (!bus.address[0]) begin
                    byte_en = bus.address[1] ? 4'b1100 : 4'b0011;
                end
                wr_lanes = {2{bus.write_data[15:0]}};
            end
            3'd2: begin
                if (bus.address[1:0] == 2'b00) begin
                    byte_en = 4'b1111;
                end
            end
            default: byte_en = 4'b0000;
        endcase
    end

    assign tick     = en_reg && (pre_cnt_reg >= prescale_reg);
    assign boundary = tick && (pwm_cnt_reg == 8'hFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_reg       <= 1'b0;
            prescale_reg <= PRESCALE_RST;
        end else if (wr_en) begin
            if (sel == 2'd0 && byte_en[0]) begin
                en_reg <= wr_lanes[0];
            end
            if (sel == 2'd1) begin
                if (byte_en[0]) prescale_reg[7:0]  <= wr_lanes[7:0];
                if (byte_en[1]) prescale_reg[15:8] <= wr_lanes[15:8];
            end
        end
    end

    // Comparing with >= lets a shrinking PRESCALE take effect on the very next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_reg <= 16'd0;
            pwm_cnt_reg <= 8'd0;
        end else if (!en_reg) begin
            pre_cnt_reg <= 16'd0;
            pwm_cnt_reg <= 8'd0;
        end else if (tick) begin
            pre_cnt_reg <= 16'd0;
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 16'd1;
        end
    end

    // Lane gi: byte 0 = R, 1 = G, 2 = B, 3 = LED.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] shadow_reg;
        logic [7:0] active_reg;
        logic       out_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                shadow_reg <= 8'd0;
            end else if (wr_en && sel == 2'd2 && byte_en[gi]) begin
                shadow_reg <= wr_lanes[8*gi +: 8];
            end
        end

        // Active duty only changes at a period boundary, so a period never sees a mid-way change.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                active_reg <= 8'd0;
            end else if (!en_reg) begin
                active_reg <= shadow_reg;
            end else if (boundary) begin
`ifdef PWM_LED_FADE_EN
                if (active_reg < shadow_reg) begin
                    active_reg <= active_reg + 8'd1;
                end else if (active_reg > shadow_reg) begin
                    active_reg <= active_reg - 8'd1;
                end
`else
                active_reg <= shadow_reg;
`endif
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_reg <= 1'b0;
            end else begin
                out_reg <= en_reg && (pwm_cnt_reg < active_reg);
            end
        end

        assign shadow_bus[8*gi +: 8] = shadow_reg;
        assign pwm_out[gi]           = out_reg;

        if (gi < 3) begin : g_status
            assign active_bus[8*gi +: 8] = active_reg;
        end
    end

    always_comb begin
        read_word = 32'd0;
        case (sel)
            2'd0: read_word = {31'd0, en_reg};
            2'd1: read_word = {16'd0, prescale_reg};
            2'd2: read_word = shadow_bus;
            2'd3: read_word = {active_bus, pwm_cnt_reg};
            default: read_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_reg <= 32'd0;
        end else begin
            read_data_reg <= bus.hit ? read_word : 32'd0;
        end
    end

    assign bus.read_data = read_data_reg;
    assign red           = pwm_out[0];
    assign green         = pwm_out[1];
    assign blue          = pwm_out[2];
    assign led           = pwm_out[3];

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Directed bench for pwm_led_ctrl: register access, duty-cycle counts, boundary loads,
// prescaler retiming, enable/reset behaviour. All steps are aligned to 1 ns after posedge.
module tb_pwm_led_ctrl;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic led, red, green, blue;

    pwm_led_ctrl_if bus ();

    pwm_led_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led),
        .red   (red),
        .green (green),
        .blue  (blue)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, led, red, green, blue};
    endfunction

    task automatic idle(input int n);
        bus.write_mem = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] off, input logic [2:0] f3, input logic [31:0] data);
        bus.address    = BASE + off;
        bus.funct3     = f3;
        bus.write_data = data;
        bus.write_mem  = 1'b1;
        @(posedge clk);
        #1;
        bus.write_mem  = 1'b0;
        $display("wr off=0x%02h funct3=%0d data=0x%08h", off[7:0], f3, data);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
        bus.address   = BASE + off;
        bus.funct3    = 3'd2;
        bus.write_mem = 1'b0;
        @(posedge clk);
        #1;
        $display("rd off=0x%02h data=0x%08h", off[7:0], bus.read_data);
        check(tag, bus.read_data, exp);
    endtask

    int hi_led, hi_red, hi_green, hi_blue;

    initial begin
        bus.write_mem  = 1'b0;
        bus.funct3     = 3'd2;
        bus.address    = 32'd0;
        bus.write_data = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", outs(), 32'd0);
        check("rst_rdata", bus.read_data, 32'd0);
        reset = 1'b1;

        rd_check("rd_ctrl", 32'h0, 32'd0);
        rd_check("rd_prescale", 32'h4, 32'd46);
        rd_check("rd_duty", 32'h8, 32'd0);
        rd_check("rd_status", 32'hC, 32'd0);
        rd_check("rd_outside", 32'h10, 32'd0);

        bus.address = BASE + 32'hC;
        #1 check("hit_top", {31'd0, bus.hit}, 32'd1);
        bus.address = BASE + 32'h10;
        #1 check("hit_above", {31'd0, bus.hit}, 32'd0);
        bus.address = BASE - 32'h4;
        #1 check("hit_below", {31'd0, bus.hit}, 32'd0);

        // Program while disabled so the active duty tracks the shadow straight away.
        bus_wr(32'h4, 3'd2, 32'd3);
        bus_wr(32'h8, 3'd2, 32'h80FF4000);
        rd_check("shadow_sw", 32'h8, 32'h80FF4000);
        rd_check("status_track", 32'hC, 32'hFF400000);
        bus_wr(32'h0, 3'd2, 32'd1);
        check("en_out_lag", outs(), 32'd0);

        hi_led = 0; hi_red = 0; hi_green = 0; hi_blue = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("first_step", outs(), 32'b1011);
            hi_led   += int'(led);
            hi_red   += int'(red);
            hi_green += int'(green);
            hi_blue  += int'(blue);
        end
        check("cnt_led_128", hi_led, 512);
        check("cnt_red_0", hi_red, 0);
        check("cnt_green_64", hi_green, 256);
        check("cnt_blue_255", hi_blue, 1020);

        // pwm_cnt is now 0 at a period start; 400 cycles puts it at 100.
        idle(400);
        bus_wr(32'h8, 3'd2, 32'h11223344);
        rd_check("status_mid", 32'hC, 32'hFF400064);
        rd_check("shadow_new", 32'h8, 32'h11223344);
        idle(620);
        rd_check("status_pre_wrap", 32'hC, 32'hFF4000FF);
        rd_check("status_post_wrap", 32'hC, 32'h22334400);

        bus_wr(32'hA, 3'd0, 32'h0000007F);
        rd_check("sb_lane2", 32'h8, 32'h117F3344);
        bus_wr(32'h9, 3'd1, 32'h0000ABCD);
        bus_wr(32'h6, 3'd2, 32'hDEADBEEF);
        bus_wr(32'h8, 3'd3, 32'hCAFEF00D);
        rd_check("sh_odd_dropped", 32'h8, 32'h117F3344);
        rd_check("sw_misalign_dropped", 32'h4, 32'd3);
        bus_wr(32'hA, 3'd1, 32'h0000BEEF);
        rd_check("sh_upper", 32'h8, 32'hBEEF3344);
        bus_wr(32'h1, 3'd0, 32'h000000FE);
        rd_check("sb_ctrl_hi", 32'h0, 32'd1);

        // Restart counters from zero, let pre_cnt reach 500, then shrink PRESCALE.
        bus_wr(32'h0, 3'd2, 32'd0);
        bus_wr(32'h4, 3'd2, 32'd1000);
        bus_wr(32'h0, 3'd2, 32'd1);
        idle(500);
        bus_wr(32'h4, 3'd2, 32'd10);
        rd_check("presc_before_tick", 32'hC, 32'hEF334400);
        rd_check("presc_forced_tick", 32'hC, 32'hEF334401);
        idle(9);
        rd_check("presc_hold_10", 32'hC, 32'hEF334401);
        rd_check("presc_tick_11", 32'hC, 32'hEF334402);

        bus_wr(32'h0, 3'd2, 32'd0);
        bus_wr(32'h8, 3'd2, 32'hFFFFFFFF);
        bus_wr(32'h4, 3'd2, 32'd3);
        bus_wr(32'h0, 3'd2, 32'd1);
        idle(1);
        check("all_high", outs(), 32'hF);
        idle(10);
        check("still_high", outs(), 32'hF);
        bus_wr(32'h0, 3'd2, 32'd0);
        idle(1);
        check("en_off_outs", outs(), 32'd0);
        rd_check("en_off_cnt", 32'hC, 32'hFFFFFF00);

        bus_wr(32'h0, 3'd2, 32'd1);
        idle(2);
        check("pre_reset_high", outs(), 32'hF);
        #2 reset = 1'b0;
        #1;
        check("async_rst_outs", outs(), 32'd0);
        check("async_rst_rdata", bus.read_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd_check("rst_ctrl", 32'h0, 32'd0);
        rd_check("rst_prescale", 32'h4, 32'd46);
        rd_check("rst_shadow", 32'h8, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
